// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the one-outstanding dmem
// protocol; fixed-latency completion with read data and error flag.

package dmem_pkg;
    typedef logic [31:0] word32_t;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    input  logic    dmem_read_i,
    input  logic    dmem_write_i,
    input  word32_t dmem_addr_i,
    input  word32_t dmem_data_i,
    output word32_t dmem_rd_data_o,
    output logic    dmem_done_o,
    output logic    dmem_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    word32_t mem [DEPTH_WORDS];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rd_q, is_rd_d;
    logic            legal_q, legal_d;
    word32_t         hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    word32_t         rd_data_q, rd_data_d;

    logic            req;
    logic            accept;
    logic            legal_req;
    logic            misaligned;
    logic            out_of_range;
    logic            we;
    logic [AW-1:0]   idx;
    word32_t         rd_word;

    // Request decode: legality, word index and the value a read would return.
    always_comb begin
        req          = dmem_read_i | dmem_write_i;
        idx          = dmem_addr_i[2 +: AW];
        misaligned   = dmem_addr_i[1:0] != 2'b00;
        out_of_range = (dmem_addr_i >> (AW + 2)) != '0;
        legal_req    = !misaligned && !out_of_range
                       && !(dmem_read_i && dmem_write_i);
        accept       = (state_q == IDLE) && req;
        rd_word      = legal_req ? mem[idx] : '0;
        // Gated by reset so strobes seen while in reset never reach the array.
        we           = accept && legal_req && dmem_write_i && reset_ni;
    end

    // Next-state: accept in IDLE, count down in BUSY, done pulse when the count expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rd_d   = is_rd_q;
        legal_d   = legal_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY);
                    is_rd_d = dmem_read_i;
                    legal_d = legal_req;
                    hold_d  = rd_word;
                    // With a one-cycle latency the done pulse is raised at the accept edge.
                    if (LATENCY == 1) begin
                        done_d = 1'b1;
                        err_d  = !legal_req;
                        if (dmem_read_i) begin
                            rd_data_d = rd_word;
                        end
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    // Done is registered, so it is raised one count early.
                    if (LATENCY >= 2 && cnt_q == CW'(2)) begin
                        done_d = 1'b1;
                        err_d  = !legal_q;
                        if (is_rd_q) begin
                            rd_data_d = hold_q;
                        end
                    end
                end
            end
        endcase
    end

    // Control and output registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_rd_q   <= 1'b0;
            legal_q   <= 1'b0;
            hold_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rd_q   <= is_rd_d;
            legal_q   <= legal_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Word array write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= dmem_data_i;
        end
    end

    assign dmem_rd_data_o = rd_data_q;
    assign dmem_done_o    = done_q;
    assign dmem_err_o     = err_q;

endmodule
